// File: rtl/xor4_chk_pkg.sv
// Shared types and constants for the 4-input XOR lab response checkers.
package xor4_chk_pkg;

  // Checker run state: waiting, sampling, verdict held.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the applied stimulus vector {a,b,c,d}.
  localparam int VEC_W = 4;

  // Coverage value meaning every one of the 16 vectors has been seen.
  localparam logic [15:0] FULL_COV = 16'hFFFF;

endpackage : xor4_chk_pkg

// File: rtl/parity4.sv
// Expected-value function for the 4-input parity lab gates.
// INVERT=0 gives XOR parity, INVERT=1 gives the XNOR variant.
module parity4
  import xor4_chk_pkg::*;
#(
  parameter bit INVERT = 1'b0
) (
  input  logic [VEC_W-1:0] vec,
  output logic             expected
);

  // Pure combinational reduction; no state here so it can be reused freely.
  assign expected = (^vec) ^ INVERT;

endmodule : parity4

// File: rtl/xor4_response_checker.sv
// Response checker for the exhaustive a/b/c/d sweep of a 4-input XOR gate.
// Compares each sampled gate output with the expected parity, tracks which
// of the 16 vectors were seen, counts mismatches and reports a verdict.
// Optional feature: define XOR4_CHK_FIRST_ERR_EN to add first_err_vec and
// first_err_valid, which capture the vector of the first mismatch in a run.
module xor4_response_checker
  import xor4_chk_pkg::*;
#(
  parameter int INVERT      = 0,   // 0: expect XOR, 1: expect XNOR
  parameter int ERR_CNT_W   = 8,   // mismatch counter width (saturating)
  parameter int MAX_SAMPLES = 64   // sample budget per run, 16..255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sample_valid,
  input  logic [VEC_W-1:0]     vec,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
`ifdef XOR4_CHK_FIRST_ERR_EN
  output logic [VEC_W-1:0]     first_err_vec,
  output logic                 first_err_valid,
`endif
  output logic [15:0]          coverage
);

  // The budget comparison uses the 8-bit sample counter width.
  localparam logic [7:0] BUDGET = MAX_SAMPLES[7:0];

  state_t               state;
  logic [7:0]           sample_cnt;

  logic                 expected;
  logic                 mismatch;
  logic [ERR_CNT_W-1:0] err_next;
  logic [15:0]          cov_next;
  logic [7:0]           cnt_next;
  logic                 finish;
  logic                 pass_next;

  parity4 #(
    .INVERT (INVERT != 0)
  ) u_parity4 (
    .vec      (vec),
    .expected (expected)
  );

  // Next values for an accepted sample; the completion test and the verdict
  // both include the current sample so the last error is never lost.
  always_comb begin
    mismatch  = (dut_out != expected);
    err_next  = err_cnt;
    if (mismatch && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_next = err_cnt + 1'b1;
    end
    cov_next  = coverage | (16'd1 << vec);
    cnt_next  = sample_cnt + 8'd1;
    finish    = (cov_next == FULL_COV) || (cnt_next == BUDGET);
    pass_next = (err_next == '0) && (cov_next == FULL_COV);
  end

  // Run-control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      coverage        <= '0;
      sample_cnt      <= '0;
`ifdef XOR4_CHK_FIRST_ERR_EN
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          // Samples are ignored here; start (re)launches a clean run.
          if (start) begin
            state           <= RUN;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            coverage        <= '0;
            sample_cnt      <= '0;
`ifdef XOR4_CHK_FIRST_ERR_EN
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
`endif
          end
        end
        RUN: begin
          // start is deliberately ignored while a run is in progress.
          if (sample_valid) begin
            err_cnt    <= err_next;
            coverage   <= cov_next;
            sample_cnt <= cnt_next;
`ifdef XOR4_CHK_FIRST_ERR_EN
            if (mismatch && !first_err_valid) begin
              first_err_vec   <= vec;
              first_err_valid <= 1'b1;
            end
`endif
            if (finish) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= pass_next;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule : xor4_response_checker

// File: tb/tb_xor4_response_checker.sv
// Self-checking bench for xor4_response_checker.
// Four instances share one stimulus stream: default build, a 32-sample
// budget, a 2-bit error counter and the XNOR variant.
`timescale 1ns/1ps
module tb_xor4_response_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sample_valid = 1'b0;
  logic [3:0] vec = 4'd0;
  logic       dut_out = 1'b0;

  logic        d_busy, d_done, d_pass;
  logic [7:0]  d_err;
  logic [15:0] d_cov;
  logic        b_busy, b_done, b_pass;
  logic [7:0]  b_err;
  logic [15:0] b_cov;
  logic        s_busy, s_done, s_pass;
  logic [1:0]  s_err;
  logic [15:0] s_cov;
  logic        i_busy, i_done, i_pass;
  logic [7:0]  i_err;
  logic [15:0] i_cov;
`ifdef XOR4_CHK_FIRST_ERR_EN
  logic [3:0] d_fvec, b_fvec, s_fvec, i_fvec;
  logic       d_fval, b_fval, s_fval, i_fval;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  vec;
    logic        flip;
    logic [7:0]  exp_err;
    logic [15:0] exp_cov;
    logic        exp_done;
  } vec_rec_t;

  vec_rec_t tbl[16];

  always #5 clk = ~clk;

  xor4_response_checker u_dflt (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .vec(vec), .dut_out(dut_out), .busy(d_busy), .done(d_done),
    .pass(d_pass), .err_cnt(d_err),
`ifdef XOR4_CHK_FIRST_ERR_EN
    .first_err_vec(d_fvec), .first_err_valid(d_fval),
`endif
    .coverage(d_cov)
  );

  xor4_response_checker #(.MAX_SAMPLES(32)) u_bud (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .vec(vec), .dut_out(dut_out), .busy(b_busy), .done(b_done),
    .pass(b_pass), .err_cnt(b_err),
`ifdef XOR4_CHK_FIRST_ERR_EN
    .first_err_vec(b_fvec), .first_err_valid(b_fval),
`endif
    .coverage(b_cov)
  );

  xor4_response_checker #(.ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .vec(vec), .dut_out(dut_out), .busy(s_busy), .done(s_done),
    .pass(s_pass), .err_cnt(s_err),
`ifdef XOR4_CHK_FIRST_ERR_EN
    .first_err_vec(s_fvec), .first_err_valid(s_fval),
`endif
    .coverage(s_cov)
  );

  xor4_response_checker #(.INVERT(1)) u_inv (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .vec(vec), .dut_out(dut_out), .busy(i_busy), .done(i_done),
    .pass(i_pass), .err_cnt(i_err),
`ifdef XOR4_CHK_FIRST_ERR_EN
    .first_err_vec(i_fvec), .first_err_valid(i_fval),
`endif
    .coverage(i_cov)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One accepted sample; returns 1 time unit after the sampling edge.
  task automatic apply(input logic [3:0] v, input logic d);
    @(negedge clk);
    sample_valid = 1'b1;
    vec          = v;
    dut_out      = d;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    $display("sample vec=%0h out=%0b -> busy=%0b done=%0b err=%0d cov=%04h",
             v, d, d_busy, d_done, d_err, d_cov);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(d_busy), 32'd0);
    chk({tag, "_done"}, 32'(d_done), 32'd0);
    chk({tag, "_pass"}, 32'(d_pass), 32'd0);
    chk({tag, "_err"},  32'(d_err),  32'd0);
    chk({tag, "_cov"},  32'(d_cov),  32'd0);
`ifdef XOR4_CHK_FIRST_ERR_EN
    chk({tag, "_fval"}, 32'(d_fval), 32'd0);
    chk({tag, "_fvec"}, 32'(d_fvec), 32'd0);
`endif
  endtask

  // Asynchronous reset checked mid-cycle, then released on a falling edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    chk_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i].vec      = 4'(i);
      tbl[i].flip     = (i == 11);
      tbl[i].exp_err  = (i >= 11) ? 8'd1 : 8'd0;
      tbl[i].exp_cov  = 16'((32'd1 << (i + 1)) - 32'd1);
      tbl[i].exp_done = (i == 15);
    end

    // Power-on reset and ignored samples in IDLE.
    #3;
    chk_zero("por");
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'd3, 1'b1);
    chk("idle_ignore_cov", 32'(d_cov), 32'd0);
    chk("idle_ignore_busy", 32'(d_busy), 32'd0);

    // Single-fault sweep from the table (vec 4'b1011 wrong).
    pulse_start();
    chk("start_busy", 32'(d_busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].vec, (^tbl[i].vec) ^ tbl[i].flip);
      chk($sformatf("tbl%0d_err", i),  32'(d_err),  32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_cov", i),  32'(d_cov),  32'(tbl[i].exp_cov));
      chk($sformatf("tbl%0d_done", i), 32'(d_done), 32'(tbl[i].exp_done));
    end
    chk("fault_pass", 32'(d_pass), 32'd0);
    chk("fault_busy", 32'(d_busy), 32'd0);
`ifdef XOR4_CHK_FIRST_ERR_EN
    chk("fault_fvec", 32'(d_fvec), 32'hB);
    chk("fault_fval", 32'(d_fval), 32'd1);
`endif
    // Samples in DONE are ignored and the verdict holds.
    apply(4'd11, 1'b0);
    chk("done_hold_err", 32'(d_err), 32'd1);
    chk("done_hold_done", 32'(d_done), 32'd1);

    // Full correct sweep.
    do_reset("rst1");
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      apply(4'(i), ^(4'(i)));
      if (i == 14) chk("sweep_not_done_15", 32'(d_done), 32'd0);
    end
    chk("sweep_done", 32'(d_done), 32'd1);
    chk("sweep_pass", 32'(d_pass), 32'd1);
    chk("sweep_err", 32'(d_err), 32'd0);
    chk("sweep_cov", 32'(d_cov), 32'hFFFF);
    chk("inv_err", 32'(i_err), 32'd16);
    chk("inv_pass", 32'(i_pass), 32'd0);
    chk("inv_done", 32'(i_done), 32'd1);

    // Budget exhaustion: vectors 0..7 four times, 32-sample instance.
    do_reset("rst2");
    pulse_start();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) begin
        apply(4'(i), ^(4'(i)));
        if (r == 3 && i == 6) chk("bud_not_done_31", 32'(b_done), 32'd0);
      end
    end
    chk("bud_done", 32'(b_done), 32'd1);
    chk("bud_cov", 32'(b_cov), 32'h00FF);
    chk("bud_err", 32'(b_err), 32'd0);
    chk("bud_pass", 32'(b_pass), 32'd0);
    chk("bud_dflt_busy", 32'(d_busy), 32'd1);

    // Saturation: first five vectors wrong.
    do_reset("rst3");
    pulse_start();
    for (int i = 0; i < 16; i++) apply(4'(i), (^(4'(i))) ^ (i < 5));
    chk("sat_err", 32'(s_err), 32'd3);
    chk("sat_pass", 32'(s_pass), 32'd0);
    chk("sat_done", 32'(s_done), 32'd1);
    chk("sat_dflt_err", 32'(d_err), 32'd5);

    // Reset mid-run after 7 samples (one wrong), asserted between edges.
    do_reset("rst4");
    pulse_start();
    for (int i = 0; i < 7; i++) apply(4'(i), (^(4'(i))) ^ (i == 2));
    chk("mid_err_before", 32'(d_err), 32'd1);
    do_reset("midrst");
    pulse_start();
    for (int i = 0; i < 16; i++) apply(4'(i), ^(4'(i)));
    chk("mid_after_pass", 32'(d_pass), 32'd1);
    chk("mid_after_done", 32'(d_done), 32'd1);

    // start inside RUN is ignored.
    do_reset("rst5");
    pulse_start();
    for (int i = 0; i < 5; i++) apply(4'(i), ^(4'(i)));
    pulse_start();
    chk("run_start_busy", 32'(d_busy), 32'd1);
    chk("run_start_cov", 32'(d_cov), 32'h001F);
    for (int i = 5; i < 16; i++) begin
      apply(4'(i), ^(4'(i)));
      if (i == 14) chk("run_start_not_done", 32'(d_done), 32'd0);
    end
    chk("run_start_done", 32'(d_done), 32'd1);
    chk("run_start_pass", 32'(d_pass), 32'd1);

    // start in DONE restarts cleanly (saturated instance had errors).
    do_reset("rst6");
    pulse_start();
    for (int i = 0; i < 16; i++) apply(4'(i), ~(^(4'(i))));
    chk("pre_restart_err", 32'(d_err), 32'd16);
    pulse_start();
    chk("restart_busy", 32'(d_busy), 32'd1);
    chk("restart_done", 32'(d_done), 32'd0);
    chk("restart_err", 32'(d_err), 32'd0);
    chk("restart_cov", 32'(d_cov), 32'd0);
`ifdef XOR4_CHK_FIRST_ERR_EN
    chk("restart_fval", 32'(d_fval), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_xor4_response_checker
